// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage and a DMA master share one memory port, with a per-access timeout.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration (default: CPU has fixed priority).
module dmem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_data_out,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        d_read_en,
    output logic        d_write_en,
    output logic [31:0] d_addr,
    output logic [31:0] d_write_data,
    input  logic [31:0] d_data_in,
    input  logic        d_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_next;
    logic [31:0] r_addr, r_wdata, r_dma_rdata;
    logic        r_we, r_dma_done, r_bus_err;
    logic [7:0]  r_cnt;

    logic w_cpu_req, w_dma_req, w_grant_cpu, w_grant_dma;
    logic w_acc, w_timeout, w_done;

`ifdef DMEM_ARB_RR_EN
    logic r_rr_ptr;  // 1: DMA wins the next simultaneous request
`endif

    assign w_cpu_req = cpu_read_en | cpu_write_en;
    // dma_req is still high in the cycle dma_done pulses; masking it avoids re-granting a finished request.
    assign w_dma_req = dma_req & ~r_dma_done;
    assign w_acc     = (r_state != IDLE);
    assign w_timeout = w_acc & ~d_ack & (r_cnt == TO_LAST);
    assign w_done    = w_acc & (d_ack | w_timeout);

    always_comb begin
        w_grant_cpu = 1'b0;
        w_grant_dma = 1'b0;
        if (r_state == IDLE) begin
            if (w_cpu_req && w_dma_req) begin
`ifdef DMEM_ARB_RR_EN
                w_grant_dma = r_rr_ptr;
                w_grant_cpu = ~r_rr_ptr;
`else
                w_grant_cpu = 1'b1;
`endif
            end else begin
                w_grant_cpu = w_cpu_req;
                w_grant_dma = w_dma_req;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_cpu)      w_state_next = CPU_ACC;
                else if (w_grant_dma) w_state_next = DMA_ACC;
            end
            CPU_ACC, DMA_ACC: begin
                if (w_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_dma_rdata <= '0;
            r_dma_done  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dma_done <= (r_state == DMA_ACC) && w_done;
            if (w_grant_cpu) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_write_data;
                r_we    <= cpu_write_en;
                r_cnt   <= '0;
            end else if (w_grant_dma) begin
                r_addr  <= dma_addr;
                r_wdata <= dma_wdata;
                r_we    <= dma_we;
                r_cnt   <= '0;
            end else if (w_acc && !d_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // A timed-out access completes with zero data.
            if ((r_state == DMA_ACC) && w_done)
                r_dma_rdata <= d_ack ? d_data_in : 32'h0;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst)             r_rr_ptr <= 1'b0;
        else if (w_grant_cpu) r_rr_ptr <= 1'b1;
        else if (w_grant_dma) r_rr_ptr <= 1'b0;
    end
`endif

    assign d_read_en    = w_acc & ~r_we;
    assign d_write_en   = w_acc & r_we;
    assign d_addr       = r_addr;
    assign d_write_data = r_wdata;
    assign cpu_data_out = w_timeout ? 32'h0 : d_data_in;
    assign cpu_stall    = w_cpu_req & ~((r_state == CPU_ACC) & w_done);
    assign dma_rdata    = r_dma_rdata;
    assign dma_done     = r_dma_done;
    assign bus_err      = r_bus_err;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, number of access cycles without d_ack before forced completion; legal range 1..255.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  reset; synchronous, active-low.
REQ-004 Port: cpu_read_en  in  1  MEM-stage load request.
REQ-005 Port: cpu_write_en  in  1  MEM-stage store request.
REQ-006 Port: cpu_addr, cpu_write_data  in  32 each  MEM-stage address and store data.
REQ-007 Port: cpu_data_out  out  32  load data to the MEM/WB register.
REQ-008 Port: cpu_stall  out  1  pipeline hold request.
REQ-009 Port: dma_req, dma_we  in  1 each  secondary-master request and write select.
REQ-010 Port: dma_addr, dma_wdata  in  32 each  secondary-master address and write data.
REQ-011 Port: dma_rdata  out  32  registered read data for the secondary master.
REQ-012 Port: dma_done  out  1  one-cycle completion pulse.
REQ-013 Port: d_read_en, d_write_en  out  1 each  memory strobes.
REQ-014 Port: d_addr, d_write_data  out  32 each  memory address and write data.
REQ-015 Port: d_data_in  in  32  memory read data.
REQ-016 Port: d_ack  in  1  memory completes the access in the cycle it is high.
REQ-017 Port: bus_err  out  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, CPU_ACC and DMA_ACC.
REQ-019 In IDLE with a request pending, the FSM SHALL latch address, write data and write select from the winning master and enter its ACC state at the next edge.
REQ-020 A CPU request SHALL be cpu_read_en or cpu_write_en; with both high, it SHALL be treated as a write.
REQ-021 In ACC states, d_read_en or d_write_en SHALL be driven from the latched select, and d_addr and d_write_data SHALL be held stable until d_ack.
REQ-022 In IDLE, both memory strobes SHALL be 0.
REQ-023 On d_ack in an ACC state, the FSM SHALL return to IDLE; any new request SHALL be arbitrated in IDLE, costing one idle cycle between accesses.
REQ-024 cpu_stall SHALL be combinational: 1 while a CPU request is present, except in the CPU_ACC cycle that carries d_ack or a timeout.
REQ-025 cpu_data_out SHALL pass through d_data_in combinationally; the minimum CPU access is 2 cycles (1 stall cycle).
REQ-026 On DMA_ACC completion, dma_rdata SHALL register d_data_in and dma_done SHALL pulse for one cycle; dma_req is held by the master until dma_done.
REQ-027 An 8-bit access counter SHALL clear on ACC entry and increment each ACC cycle without d_ack.
REQ-028 When the counter reaches TIMEOUT, the access SHALL complete as if acked with read data 0x00000000, and bus_err SHALL set and stay set until reset.
REQ-029 A request that drops in an ACC state SHALL NOT abort the access.

Reset
REQ-030 With rst low at a clock edge, the block SHALL enter IDLE and clear d_read_en, d_write_en, d_addr, d_write_data, dma_rdata, dma_done, bus_err, the counter and the round-robin pointer.
REQ-031 Reset in mid-access SHALL abandon the access without dma_done; cpu_stall SHALL then follow REQ-024 from IDLE.

Configuration
REQ-032 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a simultaneous request, the master not granted last wins, and the pointer updates on each grant.
REQ-033 With DMEM_ARB_RR_EN undefined, the CPU SHALL always win simultaneous requests.

Verification
REQ-034 CPU load of 0x100, memory acks in first ACC cycle with 0xCAFEF00D -> cpu_stall high 1 cycle; cpu_data_out=0xCAFEF00D in ack cycle.
REQ-035 DMA write of 0x12345678 to 0x200, d_ack after 3 cycles -> d_write_en high 3 cycles, address stable; dma_done pulses once.
REQ-036 CPU and DMA request simultaneously, repeated twice -> fixed priority: CPU then CPU; RR_EN: CPU then DMA.
REQ-037 TIMEOUT=4, d_ack never asserted -> completion after 4 ACC cycles; cpu_data_out=0; bus_err=1 until rst low.
REQ-038 rst low in 2nd DMA_ACC cycle -> strobes 0 next edge; no dma_done; next request granted normally.
